block_transpose_buf: RTL and testbench
======================================

BLOCK_TRANSPOSE_BUF -- requirements
Module: block_transpose_buf

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; the clock port is clk and the reset port is reset.
REQ-002 Parameter DW, default 8: element width in bits.
REQ-003 Parameter N, default 8: block dimension; the block holds N*N elements; N SHALL be a power of two, from 2 to 16.
REQ-004 Parameter AW, default log2(N*N): element index width.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 mode  input  1  output order for a block: 0 = raster, 1 = transposed.
REQ-008 in_valid  input  1  in_data holds a valid element.
REQ-009 in_data  input  DW  input element, row-major order.
REQ-010 in_ready  output  1  block can accept an element.
REQ-011 out_valid  output  1  out_data holds a valid element.
REQ-012 out_data  output  DW  output element.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 out_last  output  1  the current output element is the final element of the block.
REQ-015 blk_count  output  16  number of blocks fully unloaded since reset; wraps modulo 2^16.

Function
REQ-016 The FSM SHALL have two states, LOAD and UNLOAD.
REQ-017 In LOAD: in_ready=1 and out_valid=0; in UNLOAD: in_ready=0 and out_valid=1.
REQ-018 Input handshake: an element is accepted on a rising edge where in_valid=1 and in_ready=1; it is stored at index wr_idx, then wr_idx increments.
REQ-019 mode SHALL be sampled into an internal mode register on the acceptance of element 0 of a block; changes to mode at any other time SHALL have no effect on that block.
REQ-020 On acceptance of element N*N-1: wr_idx wraps to 0 and the state moves to UNLOAD; out_valid=1 on the very next cycle (0 idle cycles).
REQ-021 Output handshake: an element is transferred on a rising edge where out_valid=1 and out_ready=1; rd_idx then increments.
REQ-022 Read address, with rd_idx = r*N + c: raster mode reads mem[rd_idx]; transposed mode reads mem[c*N + r].
REQ-023 out_data SHALL be a combinational read of the register array at the current read address; it SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 out_last=1 exactly when the state is UNLOAD and rd_idx = N*N-1.
REQ-025 On transfer of the last element: rd_idx wraps to 0, the state moves to LOAD, and blk_count increments in the same cycle.
REQ-026 in_valid during UNLOAD SHALL be ignored; no storage write occurs and no index changes.
REQ-027 out_ready during LOAD SHALL be ignored.
REQ-028 in_data SHALL be stored unmodified; no width change, no arithmetic.
REQ-029 Stall: with out_ready=0, the block SHALL hold in UNLOAD indefinitely and keep rd_idx, out_data and out_last unchanged.

Reset
REQ-030 When reset=1 at a rising edge, the next state SHALL be: state=LOAD, wr_idx=0, rd_idx=0, mode register=0, blk_count=0, in_ready=1, out_valid=0, out_last=0.
REQ-031 Storage contents SHALL NOT be cleared by reset; out_data is don't-care while out_valid=0.
REQ-032 Reset asserted mid-LOAD or mid-UNLOAD SHALL discard the partial block; the first element accepted after reset is element 0 of a new block.
REQ-033 reset SHALL take priority over a simultaneous input or output handshake in the same cycle.

Verification
REQ-034 N=8, mode=0, load values 0..63 with in_valid held high, out_ready=1 -> out_data sequence 0,1,...,63; out_last only on value 63; out_valid rises the cycle after the 64th accept; blk_count=1.
REQ-035 N=8, mode=1, same data -> out_data sequence 0,8,16,...,56,1,9,...,63; out_last on value 63.
REQ-036 Drive mode=1 at element 0, then mode=0 from element 1 onward -> the block unloads in transposed order.
REQ-037 In UNLOAD, toggle out_ready randomly and drive in_valid=1 throughout -> output sequence is identical to the unstalled run, in_ready stays 0, and no element is overwritten.
REQ-038 Assert reset for 1 cycle after 30 accepted elements, then load 64 new values 100..163 with mode=0 -> out_data is 100..163 and blk_count=1.
REQ-039 N=4, DW=12, back-to-back blocks 0x000..0x00F then 0xFFF..0xFF0 with mode=1 on both -> two transposed blocks with no lost or duplicated elements; blk_count=2.

Source files
------------

// File: rtl/block_transpose_buf_if.sv
// ============================================================================
// Module  : block_transpose_buf_if
// Brief   : Stream-in / stream-out handshake bundle for block_transpose_buf.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface block_transpose_buf_if #(
  parameter int DW = 8
);
  logic          mode;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          out_last;
  logic [15:0]   blk_count;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, blk_count
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, blk_count
  );
endinterface

`default_nettype wire

// File: rtl/block_transpose_buf.sv
// ============================================================================
// Module  : block_transpose_buf
// Brief   : N x N block buffer; loads row-major, unloads raster or transposed.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module block_transpose_buf #(
  parameter int DW = 8,
  parameter int N  = 8,
  parameter int AW = $clog2(N*N)
) (
  input  logic                 clk,
  input  logic                 reset,
  block_transpose_buf_if.slave bus
);

  localparam int            LN       = $clog2(N);
  localparam int            DEPTH    = N * N;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  localparam logic [0:0] ST_LOAD   = 1'b0;
  localparam logic [0:0] ST_UNLOAD = 1'b1;

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic [AW-1:0] r_wr_idx;
  logic [AW-1:0] r_rd_idx;
  logic [AW-1:0] w_rd_addr;
  logic [LN-1:0] w_row;
  logic [LN-1:0] w_col;
  logic          r_mode;
  logic [15:0]   r_blk_count;
  logic [DW-1:0] r_mem [DEPTH];

  logic w_in_ready;
  logic w_out_valid;
  logic w_out_last;
  logic w_in_fire;
  logic w_out_fire;

  assign w_in_fire  = bus.in_valid  & w_in_ready;
  assign w_out_fire = w_out_valid   & bus.out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: begin
        if (w_in_fire && (r_wr_idx == LAST_IDX)) begin
          w_state_nxt = ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        if (w_out_fire && (r_rd_idx == LAST_IDX)) begin
          w_state_nxt = ST_LOAD;
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // Output decode
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_out_last  = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_in_ready = 1'b1;
      end
      ST_UNLOAD: begin
        w_out_valid = 1'b1;
        w_out_last  = (r_rd_idx == LAST_IDX);
      end
      default: begin
        w_in_ready = 1'b1;
      end
    endcase
  end

  // Indices, mode capture and block counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_mode      <= 1'b0;
      r_blk_count <= 16'd0;
    end else begin
      if (w_in_fire) begin
        r_wr_idx <= (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + AW'(1);
        if (r_wr_idx == '0) begin
          r_mode <= bus.mode;
        end
      end
      if (w_out_fire) begin
        if (r_rd_idx == LAST_IDX) begin
          r_rd_idx    <= '0;
          r_blk_count <= r_blk_count + 16'd1;
        end else begin
          r_rd_idx <= r_rd_idx + AW'(1);
        end
      end
    end
  end

  // Storage is deliberately left out of reset; contents only matter once a block is full
  always_ff @(posedge clk) begin
    if (!reset && w_in_fire) begin
      r_mem[r_wr_idx] <= bus.in_data;
    end
  end

  // rd_idx = row*N + col; transposed element lives at col*N + row
  assign w_row     = r_rd_idx[2*LN-1:LN];
  assign w_col     = r_rd_idx[LN-1:0];
  assign w_rd_addr = r_mode ? AW'({w_col, w_row}) : r_rd_idx;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_last  = w_out_last;
  assign bus.out_data  = r_mem[w_rd_addr];
  assign bus.blk_count = r_blk_count;

endmodule

`default_nettype wire

// File: tb/tb_block_transpose_buf.sv
// ============================================================================
// Module  : tb_block_transpose_buf
// Brief   : Directed scoreboard bench for block_transpose_buf (N=8 and N=4).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_block_transpose_buf;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  block_transpose_buf_if #(.DW(8))  a_if ();
  block_transpose_buf_if #(.DW(12)) b_if ();

  block_transpose_buf #(.DW(8), .N(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.slave)
  );

  block_transpose_buf #(.DW(12), .N(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.slave)
  );

  // sel routes the shared stimulus to one instance; the other sees idle inputs
  logic        sel;
  logic        mode;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_data;

  assign a_if.mode      = mode;
  assign a_if.in_valid  = in_valid & ~sel;
  assign a_if.in_data   = in_data[7:0];
  assign a_if.out_ready = out_ready & ~sel;
  assign b_if.mode      = mode;
  assign b_if.in_valid  = in_valid & sel;
  assign b_if.in_data   = in_data[11:0];
  assign b_if.out_ready = out_ready & sel;

  logic        o_in_ready;
  logic        o_valid;
  logic        o_last;
  logic [15:0] o_data;
  logic [15:0] o_blk;

  assign o_in_ready = sel ? b_if.in_ready  : a_if.in_ready;
  assign o_valid    = sel ? b_if.out_valid : a_if.out_valid;
  assign o_last     = sel ? b_if.out_last  : a_if.out_last;
  assign o_data     = sel ? 16'(b_if.out_data) : 16'(a_if.out_data);
  assign o_blk      = sel ? b_if.blk_count : a_if.blk_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int blk[256];
  bit keep_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic chk_reset_state();
    chk("rst_in_ready",  32'(o_in_ready), 32'd1);
    chk("rst_out_valid", 32'(o_valid),    32'd0);
    chk("rst_out_last",  32'(o_last),     32'd0);
    chk("rst_blk_count", 32'(o_blk),      32'd0);
  endtask

  // Drives blk[0..count-1]; mode m0 on element 0, mrest afterwards
  task automatic load_blk(input int nn, input bit m0, input bit mrest,
                          input int count, input bit full);
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
      chk("load_in_ready",  32'(o_in_ready), 32'd1);
      chk("load_out_valid", 32'(o_valid),    32'd0);
      in_valid  = 1'b1;
      in_data   = 16'(blk[i]);
      mode      = (i == 0) ? m0 : mrest;
      out_ready = 1'b1;
    end
    if (full) begin
      for (int k = 0; k < nn * nn; k++) begin
        exp_q.push_back(m0 ? blk[(k % nn) * nn + (k / nn)] : blk[k]);
      end
      @(negedge clk);
      chk("out_valid_rise", 32'(o_valid),    32'd1);
      chk("in_ready_drop",  32'(o_in_ready), 32'd0);
      out_ready = 1'b0;
      mode      = ~m0;
      in_valid  = keep_valid;
      in_data   = 16'hFAA5;
    end
  endtask

  task automatic unload_blk(input bit stall, input int exp_blk);
    int guard = 0;
    while (exp_q.size() > 0 && guard < 4000) begin
      @(negedge clk);
      guard++;
      chk("unl_out_valid", 32'(o_valid),    32'd1);
      chk("unl_in_ready",  32'(o_in_ready), 32'd0);
      chk("unl_out_data",  32'(o_data),     32'(exp_q[0]));
      chk("unl_out_last",  32'(o_last),     32'(exp_q.size() == 1));
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (keep_valid) in_data = 16'($urandom_range(0, 16'hFFFF));
      if (out_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) in_valid = 1'b0;
      end
    end
    chk("unload_budget", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_in_ready",  32'(o_in_ready), 32'd1);
    chk("post_out_valid", 32'(o_valid),    32'd0);
    chk("post_blk_count", 32'(o_blk),      32'(exp_blk));
  endtask

  initial begin
    reset      = 1'b1;
    sel        = 1'b0;
    mode       = 1'b0;
    in_valid   = 1'b0;
    in_data    = 16'd0;
    out_ready  = 1'b0;
    keep_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_reset_state();

    // Raster unload of 0..63
    for (int i = 0; i < 64; i++) blk[i] = i;
    load_blk(8, 1'b0, 1'b0, 64, 1'b1);
    unload_blk(1'b0, 1);

    // Transposed unload of the same data
    load_blk(8, 1'b1, 1'b1, 64, 1'b1);
    unload_blk(1'b0, 2);

    // Mode only sampled on element 0
    load_blk(8, 1'b1, 1'b0, 64, 1'b1);
    unload_blk(1'b0, 3);

    // Random output stalls with in_valid held high throughout UNLOAD
    for (int i = 0; i < 64; i++) blk[i] = (i * 37 + 11) & 8'hFF;
    keep_valid = 1'b1;
    load_blk(8, 1'b1, 1'b1, 64, 1'b1);
    unload_blk(1'b1, 4);
    keep_valid = 1'b0;

    // Abort a partial block with reset, then load a fresh raster block
    for (int i = 0; i < 64; i++) blk[i] = 8'hC0 + (i & 8'h3F);
    load_blk(8, 1'b1, 1'b1, 30, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    chk_reset_state();
    for (int i = 0; i < 64; i++) blk[i] = 100 + i;
    load_blk(8, 1'b0, 1'b0, 64, 1'b1);
    unload_blk(1'b0, 1);

    // N=4, DW=12: two transposed blocks back to back
    sel = 1'b1;
    @(negedge clk);
    chk_reset_state();
    for (int i = 0; i < 16; i++) blk[i] = i;
    load_blk(4, 1'b1, 1'b1, 16, 1'b1);
    unload_blk(1'b0, 1);
    for (int i = 0; i < 16; i++) blk[i] = 12'hFFF - i;
    load_blk(4, 1'b1, 1'b1, 16, 1'b1);
    unload_blk(1'b0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
